// File: rtl/rst_req_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rst_req_pkg
// Purpose  : Shared types and constants for the reset-request initiator.
// Revision : 1.0  initial release
// ============================================================================
package rst_req_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    QUALIFY      = 2'd1,
    ASSERT       = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_e;

  localparam int CAUSE_BTN = 0;
  localparam int CAUSE_WDT = 1;

  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_PULSE_CYCLES    = 16;
  localparam int unsigned DEF_WDT_CYCLES      = 2**24;

endpackage
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// ============================================================================
// Module   : bit_sync
// Purpose  : Single-bit multi-flop synchronizer, synchronous reset to 0.
// Revision : 1.0  initial release
// ============================================================================
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rst_req_debounce.sv
`default_nettype none
// ============================================================================
// Module   : rst_req_debounce
// Purpose  : Debounced pushbutton (and optional watchdog) to fixed-width
//            active-high reset request. Watchdog enabled by RST_REQ_WDT_EN.
// Revision : 1.0  initial release
// ============================================================================
module rst_req_debounce
  import rst_req_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned PULSE_CYCLES    = DEF_PULSE_CYCLES,
  parameter int unsigned WDT_CYCLES      = DEF_WDT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
`ifdef RST_REQ_WDT_EN
  input  logic       wdt_kick,
`endif
  input  logic       cause_clr,
  output logic       reset_req,
  output logic       busy,
  output logic [1:0] cause
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);

  state_e          state_q, state_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic            req_q, req_d;
  logic            busy_q, busy_d;
  logic [1:0]      cause_q, cause_d;
  logic [1:0]      cause_set;
  logic            btn_s;
  logic            wdt_expire;

  bit_sync #(.STAGES(SYNC_STAGES)) u_btn_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_s)
  );

`ifdef RST_REQ_WDT_EN
  localparam int unsigned WW = $clog2(WDT_CYCLES + 1);
  logic [WW-1:0] wcnt_q, wcnt_d;

  // A kick in the expiry cycle suppresses the expiry.
  always_comb begin
    wdt_expire = ((state_q == IDLE) || (state_q == QUALIFY)) &&
                 (wcnt_q == WW'(WDT_CYCLES - 1)) && !wdt_kick;
    if (wdt_kick || wdt_expire || (state_q == ASSERT) || (state_q == WAIT_RELEASE)) begin
      wcnt_d = '0;
    end else begin
      wcnt_d = wcnt_q + WW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end
`else
  logic wdt_cycles_unused;
  assign wdt_cycles_unused = ^WDT_CYCLES;
  assign wdt_expire        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    pcnt_d    = '0;
    cause_set = 2'b00;
    case (state_q)
      IDLE: begin
        dcnt_d = '0;
        if (btn_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d              = ASSERT;
            cause_set[CAUSE_BTN] = 1'b1;
          end else begin
            state_d = QUALIFY;
            dcnt_d  = DW'(1);
          end
        end
      end
      QUALIFY: begin
        // dcnt holds samples seen so far; the current sample completes the run.
        if (!btn_s) begin
          state_d = IDLE;
          dcnt_d  = '0;
        end else if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
          state_d              = ASSERT;
          dcnt_d               = '0;
          cause_set[CAUSE_BTN] = 1'b1;
        end else if (dcnt_q < DW'(DEBOUNCE_CYCLES)) begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      ASSERT: begin
        if (pcnt_q == PW'(PULSE_CYCLES - 1)) begin
          state_d = btn_s ? WAIT_RELEASE : IDLE;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      WAIT_RELEASE: begin
        if (!btn_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        dcnt_d  = '0;
      end
    endcase

    if (wdt_expire) begin
      state_d              = ASSERT;
      dcnt_d               = '0;
      cause_set[CAUSE_WDT] = 1'b1;
    end

    req_d   = (state_d == ASSERT);
    busy_d  = (state_d == ASSERT) || (state_d == WAIT_RELEASE);
    cause_d = (cause_clr ? 2'b00 : cause_q) | cause_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
      pcnt_q  <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      pcnt_q  <= pcnt_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      cause_q <= cause_d;
    end
  end

  assign reset_req = req_q;
  assign busy      = busy_q;
  assign cause     = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_req_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_rst_req_debounce
// Purpose  : Scoreboard bench for rst_req_debounce; RST_REQ_WDT_EN adds
//            the watchdog scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_rst_req_debounce;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 8;
  localparam int unsigned PUL  = 4;
  localparam int unsigned WDT  = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_in;
  logic       cause_clr;
`ifdef RST_REQ_WDT_EN
  logic       wdt_kick;
`endif
  logic       reset_req;
  logic       busy;
  logic [1:0] cause;

  // Expected {reset_req, busy, cause} per cycle.
  logic [3:0] sb[$];
  int         n_total = 0;
  int         n_pass  = 0;

  always #5 clk = ~clk;

  rst_req_debounce #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .PULSE_CYCLES    (PUL),
    .WDT_CYCLES      (WDT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
`ifdef RST_REQ_WDT_EN
    .wdt_kick  (wdt_kick),
`endif
    .cause_clr (cause_clr),
    .reset_req (reset_req),
    .busy      (busy),
    .cause     (cause)
  );

  task automatic do_reset();
    reset     = 1'b1;
    btn_in    = 1'b0;
    cause_clr = 1'b0;
`ifdef RST_REQ_WDT_EN
    wdt_kick  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] got, want;
    reset     = 1'b1;
    btn_in    = 1'b1;
    cause_clr = 1'b0;
`ifdef RST_REQ_WDT_EN
    wdt_kick  = 1'b0;
`endif
    for (int e = 1; e <= 8; e++) begin
      if (e == 4) begin
        reset  = 1'b0;
        btn_in = 1'b0;
      end
      sb.push_back(4'b0000);
      @(posedge clk); #1;
      got = {reset_req, busy, cause}; want = sb.pop_front();
      n_total++;
      if (got !== want) $display("FAIL reset cyc=%0d got=%b required=%b", e, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] got, want;
    do_reset();
    for (int e = 1; e <= 50; e++) begin
      btn_in = (e <= 40);
      sb.push_back({(e >= 10 && e <= 13), (e >= 10 && e <= 42),
                    (e >= 10) ? 2'b01 : 2'b00});
      @(posedge clk); #1;
      got = {reset_req, busy, cause}; want = sb.pop_front();
      n_total++;
      if (got !== want) $display("FAIL clean_press cyc=%0d got=%b required=%b", e, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_glitch_boundary();
    logic [3:0] got, want;
    do_reset();
    // 7-cycle high run must be rejected, 8-cycle run accepted.
    for (int e = 1; e <= 35; e++) begin
      btn_in = (e <= 7) || (e >= 16 && e <= 23);
      sb.push_back({(e >= 25 && e <= 28), (e >= 25 && e <= 28),
                    (e >= 25) ? 2'b01 : 2'b00});
      @(posedge clk); #1;
      got = {reset_req, busy, cause}; want = sb.pop_front();
      n_total++;
      if (got !== want) $display("FAIL glitch_boundary cyc=%0d got=%b required=%b", e, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    logic [3:0] got, want;
    bit pat [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int e = 1; e <= 105; e++) begin
      btn_in = (e <= 100) ? pat[(e - 1) % 10] : 1'b0;
`ifdef RST_REQ_WDT_EN
      wdt_kick = (e % 10 == 0);
`endif
      sb.push_back(4'b0000);
      @(posedge clk); #1;
      got = {reset_req, busy, cause}; want = sb.pop_front();
      n_total++;
      if (got !== want) $display("FAIL bounce cyc=%0d got=%b required=%b", e, got, want);
      else n_pass++;
    end
`ifdef RST_REQ_WDT_EN
    wdt_kick = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_pulse();
    logic [3:0] got, want;
    logic       act;
    do_reset();
    for (int e = 1; e <= 28; e++) begin
      btn_in = (e <= 22);
      reset  = (e == 12);
      act    = (e == 10 || e == 11 || (e >= 22 && e <= 25));
      sb.push_back({act, act, (e == 10 || e == 11 || e >= 22) ? 2'b01 : 2'b00});
      @(posedge clk); #1;
      got = {reset_req, busy, cause}; want = sb.pop_front();
      n_total++;
      if (got !== want) $display("FAIL reset_mid_pulse cyc=%0d got=%b required=%b", e, got, want);
      else n_pass++;
    end
    reset = 1'b0;
  endtask

  task automatic test_cause_clr_collision();
    logic [3:0] got, want;
    do_reset();
    for (int e = 1; e <= 30; e++) begin
      btn_in    = (e <= 20);
      cause_clr = (e == 10 || e == 20);
      sb.push_back({(e >= 10 && e <= 13), (e >= 10 && e <= 22),
                    (e >= 10 && e <= 19) ? 2'b01 : 2'b00});
      @(posedge clk); #1;
      got = {reset_req, busy, cause}; want = sb.pop_front();
      n_total++;
      if (got !== want) $display("FAIL cause_clr cyc=%0d got=%b required=%b", e, got, want);
      else n_pass++;
    end
    cause_clr = 1'b0;
  endtask

`ifdef RST_REQ_WDT_EN
  task automatic test_wdt_timeout();
    logic [3:0] got, want;
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      sb.push_back({(e >= 32 && e <= 35), (e >= 32 && e <= 35),
                    (e >= 32) ? 2'b10 : 2'b00});
      @(posedge clk); #1;
      got = {reset_req, busy, cause}; want = sb.pop_front();
      n_total++;
      if (got !== want) $display("FAIL wdt_timeout cyc=%0d got=%b required=%b", e, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_wdt_kick_periodic();
    logic [3:0] got, want;
    do_reset();
    for (int e = 1; e <= 500; e++) begin
      wdt_kick = (e % 20 == 0);
      sb.push_back(4'b0000);
      @(posedge clk); #1;
      got = {reset_req, busy, cause}; want = sb.pop_front();
      n_total++;
      if (got !== want) $display("FAIL wdt_kick_periodic cyc=%0d got=%b required=%b", e, got, want);
      else n_pass++;
    end
    wdt_kick = 1'b0;
  endtask

  task automatic test_wdt_kick_expiry();
    logic [3:0] got, want;
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      wdt_kick = (e == 32);
      sb.push_back(4'b0000);
      @(posedge clk); #1;
      got = {reset_req, busy, cause}; want = sb.pop_front();
      n_total++;
      if (got !== want) $display("FAIL wdt_kick_expiry cyc=%0d got=%b required=%b", e, got, want);
      else n_pass++;
    end
    wdt_kick = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [3:0] got, want;
    do_reset();
    // Press starts so the button qualifies on the watchdog expiry edge (32).
    for (int e = 1; e <= 50; e++) begin
      btn_in = (e >= 23 && e <= 40);
      sb.push_back({(e >= 32 && e <= 35), (e >= 32 && e <= 42),
                    (e >= 32) ? 2'b11 : 2'b00});
      @(posedge clk); #1;
      got = {reset_req, busy, cause}; want = sb.pop_front();
      n_total++;
      if (got !== want) $display("FAIL simultaneous cyc=%0d got=%b required=%b", e, got, want);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_glitch_boundary();
    test_bounce();
    test_reset_mid_pulse();
    test_cause_clr_collision();
`ifdef RST_REQ_WDT_EN
    test_wdt_timeout();
    test_wdt_kick_periodic();
    test_wdt_kick_expiry();
    test_simultaneous();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
